traffic_monitor: RTL and testbench
==================================

// Module: traffic_monitor
// PURPOSE
//  Passive observer on the traffic controller's output side. Decodes the NS/EW RGB lights and the
//  pedestrian light back into a controller phase, times how long each phase lasts, and checks it.
//  Flags: unsafe light combinations, illegal phase order, wrong phase durations.
//  Counts completed traffic cycles and pedestrian crossings.
//  Sits beside the controller at the top level; its outputs drive LEDs and ILA.
// PARAMETERS
//  CYCLES_PER_SEC  125000000  clock cycles per wall-clock second
//  TOL_CYCLES      4          allowed +/- deviation, in cycles, on every duration check
//  T_NS_G, T_NS_Y  3, 2       expected NS green / NS yellow duration, seconds
//  T_EW_G, T_EW_Y  3, 2       expected EW green / EW yellow duration, seconds
//  T_WALK, T_FLASH 2, 2       expected ped solid / ped flashing duration, seconds
// PORTS
//  clk            in   1   sole clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  i_maintenance  in   1   controller maintenance input, mirrored here
//  i_light_ns     in   3   observed NS light {r,g,b}
//  i_light_ew     in   3   observed EW light {r,g,b}
//  i_light_ped    in   1   observed pedestrian light
//  i_clear        in   1   1-cycle pulse; clears the sticky errors
//  o_phase        out  3   decoded phase (phase_t)
//  o_conflict     out  1   level: current light combination is unsafe
//  o_seq_err      out  1   sticky: an illegal phase transition was seen
//  o_timing_err   out  1   sticky: a phase ended outside its expected duration
//  o_err_phase    out  3   phase that last set o_timing_err
//  o_cycle_cnt    out  16  completed traffic cycles, wraps at 16 bits
//  o_ped_cnt      out  16  pedestrian crossings granted, wraps at 16 bits
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except o_phase = PH_UNSYNC.
//   - Internal "first phase" flag set.
//  Input stage and latency
//   - Inputs are registered once; decode and check act on the registered copy.
//   - o_phase / o_conflict respond 2 cycles after an input change.
//  Light decode
//   - Each street light is one of RED 100, YELLOW 110, GREEN 010.
//   - Any other street code forces PH_INVALID and sets o_conflict.
//  Phase decode, in priority order
//   - NS non-red and EW non-red            -> PH_INVALID, o_conflict=1
//   - ped=1 and either street non-red      -> PH_INVALID, o_conflict=1
//   - NS green / NS yellow (EW red)        -> PH_NS_G / PH_NS_Y
//   - EW green / EW yellow (NS red)        -> PH_EW_G / PH_EW_Y
//   - all red, ped=1, previous phase not FLASH -> PH_WALK
//   - all red, previous phase WALK/FLASH   -> PH_FLASH
//     (first ped fall after WALK enters FLASH; ped toggles inside FLASH do not change phase)
//   - all red otherwise                    -> PH_ALL_RED
//  Dwell counter (32 b)
//   - Counts cycles spent in the current phase; saturates at its max value.
//   - Restarts at 1 on each phase change.
//  Duration check, on every phase change
//   - The departing phase's dwell must lie within T_x*CYCLES_PER_SEC +/- TOL_CYCLES.
//   - Out of window, or saturated -> o_timing_err=1 and o_err_phase=departing phase.
//   - Not checked: the first phase after reset/maintenance (partial dwell), ALL_RED, INVALID.
//  Legal transitions
//   - NS_G->NS_Y->EW_G->EW_Y->{NS_G|WALK}
//   - WALK->FLASH->NS_G
//   - UNSYNC/ALL_RED->any
//   - Any other transition -> o_seq_err=1.
//   - Entering or leaving INVALID is always an error.
//  Counters
//   - o_cycle_cnt increments on EW_Y->NS_G and on FLASH->NS_G.
//   - o_ped_cnt increments on EW_Y->WALK.
//  Maintenance
//   - While i_maintenance=1: o_phase=PH_UNSYNC, no checks run, no counting.
//   - Sticky errors and counters are held.
//   - On deassert: first flag set, then decoding resumes.
//  Error clear and reset
//   - i_clear zeroes o_seq_err, o_timing_err and o_err_phase.
//   - An error detected in the same cycle as i_clear wins: it is set.
//   - rst_n assertion mid-phase returns everything to reset values immediately (asynchronous).
// STRUCTURE
//  Package traffic_pkg:
//   - light codes GREEN_LIGHT/YELLOW_LIGHT/RED_LIGHT (shared with the controller)
//   - phase_t enum: PH_NS_G=0, PH_NS_Y, PH_EW_G, PH_EW_Y, PH_WALK, PH_FLASH, PH_ALL_RED, PH_UNSYNC
//   - PH_INVALID=7 shares the code of PH_UNSYNC and is told apart internally by a flag
//  One sub-module, dwell_checker:
//   - contains the dwell counter, the window compare and saturation
//   - inputs: phase_change, expected_cycles, check_en
//   - output: err pulse
// TESTING  (CYCLES_PER_SEC=20, TOL_CYCLES=2, default T_*)
//  1 Nominal cycle: lights NS_G 60, NS_Y 40, EW_G 60, EW_Y 40, back to NS_G
//    -> phases decode in order; o_cycle_cnt=1; no errors; o_phase lags the inputs by 2 cycles.
//  2 Ped cycle: EW_Y -> all red with ped=1 for 40 -> ped toggles every 5 for 40 -> NS_G
//    -> WALK then FLASH; o_ped_cnt=1; o_cycle_cnt=1; no errors.
//  3 NS_G held 66 cycles -> o_timing_err=1, o_err_phase=PH_NS_G.
//    NS_G held 62 cycles -> no error.
//  4 NS green and EW green together for 3 cycles
//    -> o_conflict=1 for 3 cycles; o_seq_err=1 (sticky).
//    i_clear pulse -> o_seq_err=0; o_conflict stays low.
//  5 Maintenance asserted during EW_G
//    -> o_phase=UNSYNC; counters held.
//    After deassert: the partial first phase is not flagged; the next full phase is checked.
//  6 rst_n asserted mid-FLASH -> all outputs at reset values immediately.
//    i_clear and a timing error in the same cycle -> o_timing_err=1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller and its output-side monitor:
// light codes, the phase encoding and the phase-order rule.
package traffic_pkg;

  // Street light codes, {r,g,b}
  localparam logic [2:0] RED_LIGHT    = 3'b100;
  localparam logic [2:0] YELLOW_LIGHT = 3'b110;
  localparam logic [2:0] GREEN_LIGHT  = 3'b010;

  typedef enum logic [2:0] {
    PH_NS_G    = 3'd0,
    PH_NS_Y    = 3'd1,
    PH_EW_G    = 3'd2,
    PH_EW_Y    = 3'd3,
    PH_WALK    = 3'd4,
    PH_FLASH   = 3'd5,
    PH_ALL_RED = 3'd6,
    PH_UNSYNC  = 3'd7
  } phase_t;

  // INVALID shares its code with UNSYNC; a separate flag tells them apart.
  localparam phase_t PH_INVALID = PH_UNSYNC;

  // True when a street light shows one of the three legal codes.
  function automatic logic light_valid(input logic [2:0] light);
    return (light == RED_LIGHT) || (light == YELLOW_LIGHT) || (light == GREEN_LIGHT);
  endfunction

  // Legal phase order; any step into or out of INVALID is illegal.
  function automatic logic seq_legal(input phase_t from_ph, input logic from_inv,
                                     input phase_t to_ph,   input logic to_inv);
    logic ok;
    ok = 1'b0;
    if (from_inv || to_inv) begin
      ok = 1'b0;
    end else begin
      case (from_ph)
        PH_NS_G:    ok = (to_ph == PH_NS_Y);
        PH_NS_Y:    ok = (to_ph == PH_EW_G);
        PH_EW_G:    ok = (to_ph == PH_EW_Y);
        PH_EW_Y:    ok = (to_ph == PH_NS_G) || (to_ph == PH_WALK);
        PH_WALK:    ok = (to_ph == PH_FLASH);
        PH_FLASH:   ok = (to_ph == PH_NS_G);
        PH_ALL_RED: ok = 1'b1;
        PH_UNSYNC:  ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dwell_checker.sv
// Dwell counter for the current phase plus the duration window compare.
// err_o is a combinational pulse on the phase-change cycle; the parent registers it.
module dwell_checker
  import traffic_pkg::*;
#(
  parameter int unsigned TOL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phase_change_i,
  input  logic [31:0] expected_cycles_i,
  input  logic        check_en_i,
  output logic        err_o
);

  localparam logic [32:0] TOL_W = 33'(TOL_CYCLES);

  logic [31:0] cnt_q, cnt_d;
  logic        sat_s;
  logic [32:0] lo_s, hi_s, cnt_w_s;

  assign sat_s   = (cnt_q == 32'hFFFF_FFFF);
  assign cnt_w_s = {1'b0, cnt_q};

  // Next dwell count: restart at 1 on a change, otherwise count up and stick at max
  always_comb begin
    cnt_d = cnt_q;
    if (phase_change_i) begin
      cnt_d = 32'd1;
    end else if (!sat_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Acceptance window around the expected duration, clamped at zero on the low side
  always_comb begin
    hi_s = {1'b0, expected_cycles_i} + TOL_W;
    if ({1'b0, expected_cycles_i} >= TOL_W) begin
      lo_s = {1'b0, expected_cycles_i} - TOL_W;
    end else begin
      lo_s = 33'd0;
    end
  end

  // Dwell counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_o = check_en_i && phase_change_i &&
                 (sat_s || (cnt_w_s < lo_s) || (cnt_w_s > hi_s));

endmodule

// File: rtl/traffic_monitor.sv
// Passive monitor on the traffic controller outputs: decodes the lights back into a
// phase, checks phase order and phase durations, and counts cycles and crossings.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 125000000,
  parameter int unsigned TOL_CYCLES     = 4,
  parameter int unsigned T_NS_G         = 3,
  parameter int unsigned T_NS_Y         = 2,
  parameter int unsigned T_EW_G         = 3,
  parameter int unsigned T_EW_Y         = 2,
  parameter int unsigned T_WALK         = 2,
  parameter int unsigned T_FLASH        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_maintenance,
  input  logic [2:0]  i_light_ns,
  input  logic [2:0]  i_light_ew,
  input  logic        i_light_ped,
  input  logic        i_clear,
  output logic [2:0]  o_phase,
  output logic        o_conflict,
  output logic        o_seq_err,
  output logic        o_timing_err,
  output logic [2:0]  o_err_phase,
  output logic [15:0] o_cycle_cnt,
  output logic [15:0] o_ped_cnt
);

  localparam logic [31:0] EXP_NS_G  = 32'(T_NS_G  * CYCLES_PER_SEC);
  localparam logic [31:0] EXP_NS_Y  = 32'(T_NS_Y  * CYCLES_PER_SEC);
  localparam logic [31:0] EXP_EW_G  = 32'(T_EW_G  * CYCLES_PER_SEC);
  localparam logic [31:0] EXP_EW_Y  = 32'(T_EW_Y  * CYCLES_PER_SEC);
  localparam logic [31:0] EXP_WALK  = 32'(T_WALK  * CYCLES_PER_SEC);
  localparam logic [31:0] EXP_FLASH = 32'(T_FLASH * CYCLES_PER_SEC);

  // Registered copies of the inputs
  logic [2:0]  ns_q, ew_q;
  logic        ped_q, maint_q, clear_q;

  // Decoded state and outputs
  phase_t      phase_q, phase_s;
  logic        inv_q, inv_s, conf_s, conflict_q;
  logic        first_q, first_d;
  logic        seq_err_q, seq_err_d, timing_err_q, timing_err_d;
  logic [2:0]  err_phase_q, err_phase_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d, ped_cnt_q, ped_cnt_d;

  // Event strobes
  logic        ns_red_s, ew_red_s, change_s, tracking_s;
  logic        seq_ev_s, check_en_s, tim_ev_s, cyc_inc_s, ped_inc_s;
  logic [31:0] exp_s;

  // Input stage; maint_q resets high so the cycle before real data arrives is held unsynced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_q    <= RED_LIGHT;
      ew_q    <= RED_LIGHT;
      ped_q   <= 1'b0;
      maint_q <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      ns_q    <= i_light_ns;
      ew_q    <= i_light_ew;
      ped_q   <= i_light_ped;
      maint_q <= i_maintenance;
      clear_q <= i_clear;
    end
  end

  assign ns_red_s = (ns_q == RED_LIGHT);
  assign ew_red_s = (ew_q == RED_LIGHT);

  // Phase decode from the registered lights, in priority order
  always_comb begin
    phase_s = PH_ALL_RED;
    inv_s   = 1'b0;
    conf_s  = 1'b0;
    if (maint_q) begin
      phase_s = PH_UNSYNC;
    end else if (!light_valid(ns_q) || !light_valid(ew_q) ||
                 (!ns_red_s && !ew_red_s) ||
                 (ped_q && (!ns_red_s || !ew_red_s))) begin
      phase_s = PH_INVALID;
      inv_s   = 1'b1;
      conf_s  = 1'b1;
    end else if (ns_q == GREEN_LIGHT) begin
      phase_s = PH_NS_G;
    end else if (ns_q == YELLOW_LIGHT) begin
      phase_s = PH_NS_Y;
    end else if (ew_q == GREEN_LIGHT) begin
      phase_s = PH_EW_G;
    end else if (ew_q == YELLOW_LIGHT) begin
      phase_s = PH_EW_Y;
    end else if (ped_q && (phase_q != PH_FLASH)) begin
      phase_s = PH_WALK;
    end else if ((phase_q == PH_WALK) || (phase_q == PH_FLASH)) begin
      // Ped toggling while flashing stays in FLASH
      phase_s = PH_FLASH;
    end else begin
      phase_s = PH_ALL_RED;
    end
  end

  assign change_s   = (phase_s != phase_q) || (inv_s != inv_q);
  assign tracking_s = change_s && !maint_q;
  assign seq_ev_s   = tracking_s && !seq_legal(phase_q, inv_q, phase_s, inv_s);
  assign check_en_s = tracking_s && !first_q && !inv_q &&
                      (phase_q != PH_ALL_RED) && (phase_q != PH_UNSYNC);
  assign cyc_inc_s  = tracking_s && (phase_s == PH_NS_G) &&
                      ((phase_q == PH_EW_Y) || (phase_q == PH_FLASH));
  assign ped_inc_s  = tracking_s && (phase_q == PH_EW_Y) && (phase_s == PH_WALK);

  // Expected duration of the phase currently being timed
  always_comb begin
    case (phase_q)
      PH_NS_G:  exp_s = EXP_NS_G;
      PH_NS_Y:  exp_s = EXP_NS_Y;
      PH_EW_G:  exp_s = EXP_EW_G;
      PH_EW_Y:  exp_s = EXP_EW_Y;
      PH_WALK:  exp_s = EXP_WALK;
      PH_FLASH: exp_s = EXP_FLASH;
      default:  exp_s = 32'd0;
    endcase
  end

  dwell_checker #(
    .TOL_CYCLES (TOL_CYCLES)
  ) u_dwell (
    .clk               (clk),
    .rst_n             (rst_n),
    .phase_change_i    (change_s),
    .expected_cycles_i (exp_s),
    .check_en_i        (check_en_s),
    .err_o             (tim_ev_s)
  );

  // Next values of the first-phase flag, sticky errors and counters
  always_comb begin
    first_d      = first_q;
    seq_err_d    = seq_err_q;
    timing_err_d = timing_err_q;
    err_phase_d  = err_phase_q;
    cycle_cnt_d  = cycle_cnt_q;
    ped_cnt_d    = ped_cnt_q;

    // The first real phase after sync is partial; its departure clears the flag
    if (maint_q) begin
      first_d = 1'b1;
    end else if (change_s && !((phase_q == PH_UNSYNC) && !inv_q)) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end

    // Clear first, so an error seen in the same cycle still lands
    if (clear_q) begin
      seq_err_d    = 1'b0;
      timing_err_d = 1'b0;
      err_phase_d  = 3'd0;
    end else begin
      seq_err_d    = seq_err_q;
      timing_err_d = timing_err_q;
      err_phase_d  = err_phase_q;
    end

    if (seq_ev_s) begin
      seq_err_d = 1'b1;
    end else begin
      seq_err_d = seq_err_d;
    end

    if (tim_ev_s) begin
      timing_err_d = 1'b1;
      err_phase_d  = phase_q;
    end else begin
      timing_err_d = timing_err_d;
    end

    if (cyc_inc_s) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end

    if (ped_inc_s) begin
      ped_cnt_d = ped_cnt_q + 16'd1;
    end else begin
      ped_cnt_d = ped_cnt_q;
    end
  end

  // Phase, error and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_UNSYNC;
      inv_q        <= 1'b0;
      conflict_q   <= 1'b0;
      first_q      <= 1'b1;
      seq_err_q    <= 1'b0;
      timing_err_q <= 1'b0;
      err_phase_q  <= 3'd0;
      cycle_cnt_q  <= 16'd0;
      ped_cnt_q    <= 16'd0;
    end else begin
      phase_q      <= phase_s;
      inv_q        <= inv_s;
      conflict_q   <= conf_s;
      first_q      <= first_d;
      seq_err_q    <= seq_err_d;
      timing_err_q <= timing_err_d;
      err_phase_q  <= err_phase_d;
      cycle_cnt_q  <= cycle_cnt_d;
      ped_cnt_q    <= ped_cnt_d;
    end
  end

  assign o_phase      = phase_q;
  assign o_conflict   = conflict_q;
  assign o_seq_err    = seq_err_q;
  assign o_timing_err = timing_err_q;
  assign o_err_phase  = err_phase_q;
  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_ped_cnt    = ped_cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor at 20 cycles/second, tolerance 2 cycles.
// Inputs change and outputs are sampled on the falling edge.
module tb_traffic_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b110;
  localparam logic [2:0] G = 3'b010;

  localparam int P_NS_G = 0, P_NS_Y = 1, P_EW_G = 2, P_EW_Y = 3;
  localparam int P_WALK = 4, P_FLASH = 5, P_UNSYNC = 7;

  logic        clk, rst_n, i_maintenance, i_light_ped, i_clear;
  logic [2:0]  i_light_ns, i_light_ew;
  logic [2:0]  o_phase, o_err_phase;
  logic        o_conflict, o_seq_err, o_timing_err;
  logic [15:0] o_cycle_cnt, o_ped_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_monitor #(
    .CYCLES_PER_SEC (20),
    .TOL_CYCLES     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_maintenance (i_maintenance),
    .i_light_ns    (i_light_ns),
    .i_light_ew    (i_light_ew),
    .i_light_ped   (i_light_ped),
    .i_clear       (i_clear),
    .o_phase       (o_phase),
    .o_conflict    (o_conflict),
    .o_seq_err     (o_seq_err),
    .o_timing_err  (o_timing_err),
    .o_err_phase   (o_err_phase),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_ped_cnt     (o_ped_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic seg(input logic [2:0] ns, input logic [2:0] ew, input logic ped, input int n);
    i_light_ns  = ns;
    i_light_ew  = ew;
    i_light_ped = ped;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_low();
    i_light_ns    = R;
    i_light_ew    = R;
    i_light_ped   = 1'b0;
    i_maintenance = 1'b0;
    i_clear       = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic full_cycle_to_ew_y();
    seg(G, R, 1'b0, 60);
    seg(Y, R, 1'b0, 40);
    seg(R, G, 1'b0, 60);
    seg(R, Y, 1'b0, 40);
  endtask

  initial begin
    // ---------------- reset values, nominal cycle, durations, clear ----------------
    reset_low();
    check_eq("rst_phase", o_phase, P_UNSYNC);
    check_eq("rst_conflict", o_conflict, 0);
    check_eq("rst_seq", o_seq_err, 0);
    check_eq("rst_tim", o_timing_err, 0);
    check_eq("rst_errph", o_err_phase, 0);
    check_eq("rst_cyc", o_cycle_cnt, 0);
    check_eq("rst_ped", o_ped_cnt, 0);
    rst_n = 1'b1;

    seg(G, R, 1'b0, 60);
    check_eq("nom_ns_g", o_phase, P_NS_G);
    seg(Y, R, 1'b0, 1);
    check_eq("lag_1cyc", o_phase, P_NS_G);
    @(negedge clk);
    check_eq("lag_2cyc", o_phase, P_NS_Y);
    repeat (38) @(negedge clk);
    seg(R, G, 1'b0, 60);
    check_eq("nom_ew_g", o_phase, P_EW_G);
    seg(R, Y, 1'b0, 40);
    check_eq("nom_ew_y", o_phase, P_EW_Y);
    seg(G, R, 1'b0, 60);
    check_eq("nom_back_ns_g", o_phase, P_NS_G);
    check_eq("nom_cyc", o_cycle_cnt, 1);
    check_eq("nom_seq", o_seq_err, 0);
    check_eq("nom_tim", o_timing_err, 0);

    repeat (6) @(negedge clk);            // NS_G held 66 cycles
    seg(Y, R, 1'b0, 40);
    check_eq("ns_g66_tim", o_timing_err, 1);
    check_eq("ns_g66_errph", o_err_phase, P_NS_G);
    check_eq("ns_g66_seq", o_seq_err, 0);

    i_clear = 1'b1;
    seg(R, G, 1'b0, 1);
    i_clear = 1'b0;
    repeat (59) @(negedge clk);
    check_eq("clear_tim", o_timing_err, 0);
    seg(R, Y, 1'b0, 40);
    seg(G, R, 1'b0, 62);
    seg(Y, R, 1'b0, 40);
    check_eq("ns_g62_tim", o_timing_err, 0);

    seg(R, G, 1'b0, 60);
    seg(R, Y, 1'b0, 40);
    seg(G, R, 1'b0, 66);
    i_clear = 1'b1;                       // clear lands on the same cycle as the error
    seg(Y, R, 1'b0, 1);
    i_clear = 1'b0;
    repeat (39) @(negedge clk);
    check_eq("clr_vs_err_tim", o_timing_err, 1);
    check_eq("clr_vs_err_cyc", o_cycle_cnt, 3);

    // ---------------- pedestrian cycle ----------------
    reset_low();
    rst_n = 1'b1;
    full_cycle_to_ew_y();
    seg(R, R, 1'b1, 40);
    check_eq("ped_walk", o_phase, P_WALK);
    for (int k = 0; k < 8; k++) begin
      seg(R, R, logic'(k % 2), 5);
      if (k == 1) check_eq("ped_flash_toggle", o_phase, P_FLASH);
    end
    check_eq("ped_flash_end", o_phase, P_FLASH);
    seg(G, R, 1'b0, 10);
    check_eq("ped_ns_g", o_phase, P_NS_G);
    check_eq("ped_cnt", o_ped_cnt, 1);
    check_eq("ped_cyc", o_cycle_cnt, 1);
    check_eq("ped_seq", o_seq_err, 0);
    check_eq("ped_tim", o_timing_err, 0);

    // ---------------- conflicting greens ----------------
    reset_low();
    rst_n = 1'b1;
    seg(G, R, 1'b0, 60);
    seg(G, G, 1'b0, 1);
    check_eq("conf_lag", o_conflict, 0);
    @(negedge clk);
    check_eq("conf_c1", o_conflict, 1);
    @(negedge clk);
    check_eq("conf_c2", o_conflict, 1);
    check_eq("conf_phase", o_phase, P_UNSYNC);
    seg(G, R, 1'b0, 1);
    check_eq("conf_c3", o_conflict, 1);
    @(negedge clk);
    check_eq("conf_drop", o_conflict, 0);
    check_eq("conf_seq", o_seq_err, 1);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("conf_clr_seq", o_seq_err, 0);
    check_eq("conf_clr_conf", o_conflict, 0);

    // ---------------- maintenance ----------------
    reset_low();
    rst_n = 1'b1;
    full_cycle_to_ew_y();
    seg(G, R, 1'b0, 60);
    seg(Y, R, 1'b0, 40);
    seg(R, G, 1'b0, 20);
    i_maintenance = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("maint_phase", o_phase, P_UNSYNC);
    check_eq("maint_cyc", o_cycle_cnt, 1);
    i_maintenance = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("maint_resume", o_phase, P_EW_G);
    seg(R, Y, 1'b0, 20);
    check_eq("maint_partial_tim", o_timing_err, 0);
    check_eq("maint_seq", o_seq_err, 0);
    repeat (26) @(negedge clk);           // EW_Y held 46 cycles
    seg(G, R, 1'b0, 10);
    check_eq("maint_next_tim", o_timing_err, 1);
    check_eq("maint_next_errph", o_err_phase, P_EW_Y);
    check_eq("maint_next_cyc", o_cycle_cnt, 2);

    // ---------------- asynchronous reset mid-FLASH ----------------
    reset_low();
    rst_n = 1'b1;
    full_cycle_to_ew_y();
    seg(R, R, 1'b1, 40);
    seg(R, R, 1'b0, 15);
    check_eq("pre_rst_phase", o_phase, P_FLASH);
    check_eq("pre_rst_ped", o_ped_cnt, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_phase", o_phase, P_UNSYNC);
    check_eq("async_rst_ped", o_ped_cnt, 0);
    check_eq("async_rst_cyc", o_cycle_cnt, 0);
    check_eq("async_rst_tim", o_timing_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
